// File: rtl/usb_nrzi_tx_if.sv
// Bit-stream handshake between the packet FSM (master) and the NRZI transmit stage (slave).
interface usb_nrzi_tx_if;
  logic bit_in;
  logic bit_valid;
  logic bit_last;
  logic bit_ready;

  modport master (output bit_in, output bit_valid, output bit_last, input bit_ready);
  modport slave  (input bit_in, input bit_valid, input bit_last, output bit_ready);
endinterface

// File: rtl/usb_nrzi_tx.sv
// USB serial transmit stage: bit stuffing, NRZI encoding and EOP generation
// feeding the DP/DM tristate drivers.
module usb_nrzi_tx #(
  parameter int STUFF_LEN      = 6,
  parameter int EOP_SE0_CYCLES = 2
) (
  input  logic               clock,
  input  logic               reset,
  usb_nrzi_tx_if.slave       bus,
  output logic               DP_out,
  output logic               DM_out,
  output logic               sending,
  output logic               tx_done,
  output logic               underflow_err
);

  localparam int ONES_W = $clog2(STUFF_LEN + 1);
  localparam int EOP_W  = $clog2(EOP_SE0_CYCLES + 1);

  localparam logic [ONES_W-1:0] STUFF_MAX = ONES_W'(STUFF_LEN);
  localparam logic [EOP_W-1:0]  EOP_LOAD  = EOP_W'(EOP_SE0_CYCLES);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_DATA    = 3'd1;
  localparam logic [2:0] ST_STUFF   = 3'd2;
  localparam logic [2:0] ST_EOP_SE0 = 3'd3;
  localparam logic [2:0] ST_EOP_J   = 3'd4;

  localparam logic [1:0] LINE_J   = 2'b10;
  localparam logic [1:0] LINE_SE0 = 2'b00;

  logic [2:0]        state_r;
  logic [ONES_W-1:0] ones_r;
  logic [EOP_W-1:0]  eop_cnt_r;
  logic              stuff_last_r;
  logic [1:0]        line_r;
  logic              sending_r;
  logic              tx_done_r;
  logic              underflow_r;

  logic              ready_s;
  logic              xfer_s;
  logic [ONES_W-1:0] ones_base_s;
  logic [ONES_W-1:0] ones_inc_s;
  logic              stuff_hit_s;
  logic [1:0]        line_bit_s;
  logic [2:0]        acc_next_s;

  // Handshake and per-bit encoding decisions derived from the current state.
  always_comb begin
    ready_s     = 1'b0;
    ones_base_s = ones_r;
    ones_inc_s  = '0;
    stuff_hit_s = 1'b0;
    line_bit_s  = line_r;
    acc_next_s  = ST_DATA;

    if (reset) begin
      ready_s = 1'b0;
    end else if ((state_r == ST_IDLE) || (state_r == ST_DATA)) begin
      ready_s = 1'b1;
    end else begin
      ready_s = 1'b0;
    end

    // A new packet always counts ones from zero.
    if (state_r == ST_IDLE) begin
      ones_base_s = '0;
    end else begin
      ones_base_s = ones_r;
    end

    if (bus.bit_in) begin
      ones_inc_s  = ones_base_s + ONES_W'(1);
      stuff_hit_s = (ones_inc_s == STUFF_MAX);
      line_bit_s  = line_r;
    end else begin
      ones_inc_s  = '0;
      stuff_hit_s = 1'b0;
      line_bit_s  = {line_r[0], line_r[1]};
    end

    if (stuff_hit_s) begin
      acc_next_s = ST_STUFF;
    end else if (bus.bit_last) begin
      acc_next_s = ST_EOP_SE0;
    end else begin
      acc_next_s = ST_DATA;
    end
  end

  assign xfer_s        = bus.bit_valid && ready_s;
  assign bus.bit_ready = ready_s;

  // Transmit FSM; every line level is registered on the edge that leaves a cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r      <= ST_IDLE;
      ones_r       <= '0;
      eop_cnt_r    <= '0;
      stuff_last_r <= 1'b0;
      line_r       <= LINE_J;
      sending_r    <= 1'b0;
      tx_done_r    <= 1'b0;
      underflow_r  <= 1'b0;
    end else begin
      tx_done_r   <= 1'b0;
      underflow_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (xfer_s) begin
            sending_r    <= 1'b1;
            line_r       <= line_bit_s;
            ones_r       <= ones_inc_s;
            stuff_last_r <= bus.bit_last;
            eop_cnt_r    <= EOP_LOAD;
            state_r      <= acc_next_s;
          end else begin
            line_r  <= LINE_J;
            state_r <= ST_IDLE;
          end
        end
        ST_DATA: begin
          if (xfer_s) begin
            line_r       <= line_bit_s;
            ones_r       <= ones_inc_s;
            stuff_last_r <= bus.bit_last;
            eop_cnt_r    <= EOP_LOAD;
            state_r      <= acc_next_s;
          end else begin
            // Source starved mid-packet: abort with a normal EOP.
            underflow_r <= 1'b1;
            eop_cnt_r   <= EOP_LOAD;
            state_r     <= ST_EOP_SE0;
          end
        end
        ST_STUFF: begin
          line_r    <= {line_r[0], line_r[1]};
          ones_r    <= '0;
          eop_cnt_r <= EOP_LOAD;
          state_r   <= stuff_last_r ? ST_EOP_SE0 : ST_DATA;
        end
        ST_EOP_SE0: begin
          if (eop_cnt_r == '0) begin
            line_r  <= LINE_J;
            state_r <= ST_EOP_J;
          end else begin
            line_r    <= LINE_SE0;
            eop_cnt_r <= eop_cnt_r - EOP_W'(1);
          end
        end
        ST_EOP_J: begin
          line_r    <= LINE_J;
          sending_r <= 1'b0;
          tx_done_r <= 1'b1;
          state_r   <= ST_IDLE;
        end
        default: begin
          line_r    <= LINE_J;
          sending_r <= 1'b0;
          state_r   <= ST_IDLE;
        end
      endcase
    end
  end

  assign DP_out        = line_r[1];
  assign DM_out        = line_r[0];
  assign sending       = sending_r;
  assign tx_done       = tx_done_r;
  assign underflow_err = underflow_r;

endmodule

// File: tb/tb_usb_nrzi_tx.sv
// Randomised and directed checks of usb_nrzi_tx against a symbol-level model
// (stuffed NRZI line sequence followed by SE0,SE0,J).
module tb_usb_nrzi_tx;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic dp_out, dm_out, sending, tx_done, underflow_err;

  usb_nrzi_tx_if bus ();

  usb_nrzi_tx dut (
    .clock         (clock),
    .reset         (reset),
    .bus           (bus),
    .DP_out        (dp_out),
    .DM_out        (dm_out),
    .sending       (sending),
    .tx_done       (tx_done),
    .underflow_err (underflow_err)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  bit         pkt[$];
  logic [1:0] exp_q[$];
  int         uf_pos;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: stuffed NRZI symbols, one per bit time, then EOP.
  task automatic build_exp(input int drop_at);
    logic level;
    int   ones;
    int   m;
    level = 1'b1;
    ones  = 0;
    m     = (drop_at >= 0) ? drop_at : pkt.size();
    exp_q.delete();
    uf_pos = -1;
    for (int i = 0; i < m; i++) begin
      if (pkt[i] == 1'b0) begin
        level = ~level;
        ones  = 0;
      end else begin
        ones++;
      end
      exp_q.push_back({level, ~level});
      if (ones == 6) begin
        level = ~level;
        exp_q.push_back({level, ~level});
        ones = 0;
      end
    end
    if (drop_at >= 0) begin
      uf_pos = exp_q.size();
      exp_q.push_back(exp_q[exp_q.size()-1]);
    end
    exp_q.push_back(2'b00);
    exp_q.push_back(2'b00);
    exp_q.push_back(2'b10);
  endtask

  task automatic set_inputs(input int idx, input int drop_at, inout bit dropped);
    if (dropped || idx >= pkt.size()) begin
      bus.bit_valid = 1'b0;
      bus.bit_last  = 1'b0;
    end else if (idx == drop_at) begin
      bus.bit_valid = 1'b0;
      dropped       = 1'b1;
    end else begin
      bus.bit_valid = 1'b1;
      bus.bit_in    = pkt[idx];
      bus.bit_last  = (idx == pkt.size() - 1);
    end
  endtask

  task automatic run_packet(input int drop_at);
    int   idx = 0, pos = 0, waitc = 0, cyc = 0, budget;
    bit   started = 0, dropped = 0, done = 0;
    logic rdy, drove;
    build_exp(drop_at);
    budget = exp_q.size() + 12;
    set_inputs(idx, drop_at, dropped);
    while (!done && cyc < budget) begin
      @(negedge clock);
      rdy   = bus.bit_ready;
      drove = bus.bit_valid;
      @(posedge clock);
      #1;
      cyc++;
      if (rdy && drove) begin
        idx++;
        started = 1'b1;
      end
      if (!started) begin
        waitc++;
      end else if (pos < exp_q.size()) begin
        chk("line", {30'd0, dp_out, dm_out}, {30'd0, exp_q[pos]});
        chk("sending", {31'd0, sending}, 32'd1);
        chk("tx_done_early", {31'd0, tx_done}, 32'd0);
        chk("underflow", {31'd0, underflow_err}, (pos == uf_pos) ? 32'd1 : 32'd0);
        pos++;
      end else begin
        chk("end_line", {30'd0, dp_out, dm_out}, 32'd2);
        chk("end_sending", {31'd0, sending}, 32'd0);
        chk("tx_done", {31'd0, tx_done}, 32'd1);
        chk("end_ready", {31'd0, bus.bit_ready}, 32'd1);
        done = 1'b1;
      end
      set_inputs(idx, drop_at, dropped);
    end
    chk("timeout", {31'd0, done}, 32'd1);
    chk("start_lat", waitc, 32'd0);
  endtask

  task automatic idle_cycles(input int k);
    bus.bit_valid = 1'b0;
    repeat (k) begin
      @(posedge clock);
      #1;
      chk("idle_line", {30'd0, dp_out, dm_out}, 32'd2);
      chk("idle_sending", {31'd0, sending}, 32'd0);
      chk("idle_tx_done", {31'd0, tx_done}, 32'd0);
    end
  endtask

  task automatic load(input logic [63:0] bits, input int n);
    logic [63:0] v;
    v = bits;
    pkt.delete();
    for (int i = 0; i < n; i++) pkt.push_back(v[i]);
  endtask

  initial begin
    bus.bit_in    = 1'b0;
    bus.bit_valid = 1'b0;
    bus.bit_last  = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_line", {30'd0, dp_out, dm_out}, 32'd2);
    chk("rst_sending", {31'd0, sending}, 32'd0);
    chk("rst_tx_done", {31'd0, tx_done}, 32'd0);
    chk("rst_underflow", {31'd0, underflow_err}, 32'd0);
    chk("rst_ready", {31'd0, bus.bit_ready}, 32'd0);
    reset = 1'b0;
    idle_cycles(1);

    // SYNC then a final 0 (LSB-first: bit0 first).
    load(64'b0_1000_0000, 9);
    run_packet(-1);
    // Seven ones then a final 0: one stuff bit after the sixth.
    load(64'b0111_1111, 8);
    run_packet(-1);
    // Packet ends on the sixth one: stuff bit still emitted.
    load(64'b11_1111, 6);
    run_packet(-1);
    idle_cycles(2);

    // Valid drops after four accepted bits.
    load(64'b1011_0010, 8);
    run_packet(4);
    idle_cycles(2);

    // Reset during the third DATA cycle.
    bus.bit_valid = 1'b1;
    bus.bit_in    = 1'b1;
    bus.bit_last  = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;
    @(posedge clock);
    #1;
    chk("mid_rst_sending", {31'd0, sending}, 32'd0);
    chk("mid_rst_line", {30'd0, dp_out, dm_out}, 32'd2);
    chk("mid_rst_tx_done", {31'd0, tx_done}, 32'd0);
    chk("mid_rst_ready", {31'd0, bus.bit_ready}, 32'd0);
    reset = 1'b0;
    idle_cycles(3);
    load(64'b01_1111, 6);
    run_packet(-1);

    // Random packets, many of them back-to-back.
    for (int p = 0; p < 30; p++) begin
      int n;
      n = $urandom_range(1, 40);
      pkt.delete();
      for (int i = 0; i < n; i++) pkt.push_back($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 2) == 0) idle_cycles($urandom_range(1, 3));
      run_packet(-1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
